// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Grant is held for a whole packet; a watchdog recovers from a hung transmitter.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BYTE_WIDTH = 8,
  parameter int TIMEOUT    = 200000
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*BYTE_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [BYTE_WIDTH-1:0]         tx_data,
  output logic                          tx_start,
  input  logic                          tx_done,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int          IW = $clog2(NUM_REQ);
  localparam int          CW = $clog2(TIMEOUT + 1);
  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [1:0] {IDLE, START, WAIT, NEXT} state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          rr_ptr, winner, sel, ptr_after;
  logic                   win_valid, owner_valid, accept, wdog_hit, timeout, pkt_open;
  logic [CW-1:0]          wdog;
  logic [BYTE_WIDTH-1:0]  sel_byte;

  always_comb begin : rr_search
    logic [IW-1:0] idx;
    idx       = '0;
    winner    = '0;
    win_valid = 1'b0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = IW'((32'(rr_ptr) + k) % NR);
      if (!win_valid && req_valid[idx]) begin
        win_valid = 1'b1;
        winner    = idx;
      end
    end
  end

  always_comb begin
    sel_byte = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (sel == IW'(i)) sel_byte = req_data[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  assign owner_valid = req_valid[grant_id];
  assign sel         = (state == IDLE) ? winner : grant_id;
  assign accept      = (state == IDLE && win_valid) || (state == NEXT && owner_valid);
  assign ptr_after   = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign wdog_hit    = (wdog == CW'(TIMEOUT - 1));
  // A completing frame or an accepted byte in the expiry cycle beats the watchdog.
  assign timeout     = wdog_hit && ((state == WAIT && !tx_done) || (state == NEXT && !owner_valid));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (win_valid) state_nxt = START;
      START: state_nxt = WAIT;
      WAIT: begin
        if (tx_done)      state_nxt = pkt_open ? NEXT : IDLE;
        else if (timeout) state_nxt = IDLE;
      end
      NEXT: begin
        if (owner_valid)  state_nxt = START;
        else if (timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && win_valid) req_ready[winner]   = 1'b1;
    else if (state == NEXT)         req_ready[grant_id] = owner_valid;
    tx_start    = (state == START);
    busy        = (state != IDLE);
    timeout_err = timeout;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tx_data  <= '0;
      grant_id <= '0;
      pkt_open <= 1'b0;
      rr_ptr   <= '0;
      wdog     <= '0;
    end else begin
      if (accept) begin
        tx_data  <= sel_byte;
        pkt_open <= ~req_last[sel];
      end
      if (state == IDLE && win_valid) grant_id <= winner;
      if ((state == WAIT && tx_done && !pkt_open) || timeout) rr_ptr <= ptr_after;
      if (timeout) pkt_open <= 1'b0;
      if ((state == WAIT || state == NEXT) && !(state == WAIT && tx_done) && !timeout)
        wdog <= (wdog == CW'(TIMEOUT)) ? wdog : wdog + 1'b1;
      else
        wdog <= '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: packet-level round-robin model predicts
// accepts, transmitted bytes and watchdog aborts; a monitor checks DUT outputs.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int BW = 8;
  localparam int TO = 50;
  localparam int IW = $clog2(N);

  logic              clk = 1'b0;
  logic              arst_n = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*BW-1:0]   req_data = '0;
  logic [N-1:0]      req_last = '0;
  logic [N-1:0]      req_ready;
  logic [BW-1:0]     tx_data;
  logic              tx_start;
  logic              tx_done = 1'b0;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic              timeout_err;

  uart_tx_arbiter #(.NUM_REQ(N), .BYTE_WIDTH(BW), .TIMEOUT(TO)) dut (
    .clk(clk), .arst_n(arst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_start(tx_start), .tx_done(tx_done), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;

  typedef struct { logic [BW-1:0] data; logic last; } rq_t;
  typedef struct { logic [BW-1:0] data; int id; int cyc; } tx_exp_t;
  typedef enum { M_FREE, M_LOCKED, M_INFLIGHT } mphase_t;

  rq_t     rq[N][$];
  tx_exp_t sbq[$];
  int      toq[$];

  mphase_t m_phase = M_FREE;
  int      m_ptr = 0, m_owner = 0, m_deadline = 0;
  bit      m_open = 0;

  int done_at = -1;
  bit hang = 0;
  int dmin = 2, dmax = 6;
  int gate_pct = 100;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int r, logic [BW-1:0] d, logic l);
    rq[r].push_back('{data: d, last: l});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 0;
    return 1;
  endfunction

  // One clock cycle: drive inputs, advance the reference model, check ready/busy.
  task automatic step();
    logic [N-1:0] v, er;
    int win, j;
    @(negedge clk);
    tx_done = (done_at == cyc);
    if (tx_done) done_at = -1;
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0 && $urandom_range(99) < gate_pct) begin
        v[i] = 1'b1;
        req_data[i*BW +: BW] = rq[i][0].data;
        req_last[i] = rq[i][0].last;
      end else begin
        v[i] = 1'b0;
        req_data[i*BW +: BW] = BW'($urandom);
        req_last[i] = 1'($urandom_range(1));
      end
    end
    req_valid = v;
    #1;
    if (tx_start && !hang) done_at = cyc + int'($urandom_range(dmin, dmax));
    check("busy", busy, (m_phase != M_FREE));
    er = '0;
    win = -1;
    if (m_phase == M_FREE) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (win < 0 && v[j]) win = j;
      end
    end else if (m_phase == M_LOCKED && v[m_owner]) begin
      win = m_owner;
    end
    if (win >= 0) er[win] = 1'b1;
    check("req_ready", req_ready, er);
    if (win >= 0) begin
      sbq.push_back('{data: rq[win][0].data, id: win, cyc: cyc + 1});
      m_open     = !rq[win][0].last;
      m_owner    = win;
      m_phase    = M_INFLIGHT;
      m_deadline = cyc + 1 + TO;
      void'(rq[win].pop_front());
    end else if (m_phase == M_INFLIGHT && tx_done) begin
      if (m_open) begin
        m_phase    = M_LOCKED;
        m_deadline = cyc + TO;
      end else begin
        m_phase = M_FREE;
        m_ptr   = (m_owner + 1) % N;
      end
    end else if (m_phase != M_FREE && cyc == m_deadline) begin
      toq.push_back(cyc);
      m_phase = M_FREE;
      m_ptr   = (m_owner + 1) % N;
    end
  endtask

  task automatic drain(int budget);
    int n;
    bit quiet;
    n = 0;
    quiet = 0;
    while (!quiet && n < budget) begin
      step();
      n++;
      quiet = all_empty() && m_phase == M_FREE && done_at < 0;
    end
    check("drain_done", quiet, 1);
    step();
    step();
    check("sb_empty", sbq.size(), 0);
    check("timeout_q_empty", toq.size(), 0);
  endtask

  // Monitor: every tx_start / timeout_err pulse is matched against the scoreboard.
  initial begin
    tx_exp_t e;
    int t;
    forever begin
      @(negedge clk);
      #2;
      if (arst_n && tx_start) begin
        check("tx_start_expected", (sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("tx_data", tx_data, e.data);
          check("grant_id", grant_id, e.id);
          check("tx_start_cycle", cyc, e.cyc);
        end
      end
      if (arst_n && timeout_err) begin
        check("timeout_expected", (toq.size() > 0), 1);
        if (toq.size() > 0) begin
          t = toq.pop_front();
          check("timeout_cycle", cyc, t);
        end
      end
    end
  end

  initial begin
    #1 arst_n = 1'b0;
    #12;
    check("rst_tx_start", tx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_req_ready", req_ready, 0);
    @(negedge clk);
    arst_n = 1'b1;

    push(0, 8'hA5, 1'b1);
    drain(200);

    for (int i = 0; i < N; i++) push(i, BW'(8'h10 + i), 1'b1);
    drain(400);

    push(1, 8'h21, 1'b1);
    drain(200);
    push(2, 8'h55, 1'b0);
    push(2, 8'h66, 1'b0);
    push(2, 8'h77, 1'b1);
    push(1, 8'h99, 1'b1);
    drain(400);

    hang = 1;
    push(0, 8'h3C, 1'b1);
    drain(TO * 3);
    hang = 0;

    dmin = TO;
    dmax = TO;
    push(1, 8'h5A, 1'b1);
    drain(TO * 3);
    dmin = 2;
    dmax = 6;

    push(3, 8'hC7, 1'b0);
    push(0, 8'h0F, 1'b1);
    drain(TO * 4);

    dmin = 20;
    dmax = 20;
    push(2, 8'hC3, 1'b1);
    repeat (4) step();
    #1;
    req_valid = '0;
    arst_n = 1'b0;
    #1;
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grant_id", grant_id, 0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_timeout_err", timeout_err, 0);
    check("mid_rst_req_ready", req_ready, 0);
    sbq.delete();
    toq.delete();
    done_at = -1;
    tx_done = 1'b0;
    m_phase = M_FREE;
    m_ptr = 0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    dmin = 2;
    dmax = 6;
    push(1, 8'h45, 1'b1);
    push(0, 8'h44, 1'b1);
    drain(300);

    gate_pct = 75;
    for (int p = 0; p < 200; p++) begin
      int r, len;
      r = int'($urandom_range(N - 1));
      len = int'($urandom_range(1, 3));
      dmin = 1;
      dmax = int'($urandom_range(1, 20));
      for (int b = 0; b < len; b++) push(r, BW'($urandom), (b == len - 1));
      repeat ($urandom_range(0, 12)) step();
    end
    drain(20000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
